// File: rtl/imm_ext_stage.sv
// RISC-V immediate extender for decode: decodes I/S/B/U/J/SHAMT immediates to XLEN
// and holds them in a 2-entry skid FIFO with valid/ready on both sides.
module imm_ext_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:7]     Instr,
  input  logic [2:0]      ImmSrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ImmExt,
  output logic            ImmSrcErr
);

  typedef enum logic [2:0] {
    SRC_I     = 3'b000,
    SRC_S     = 3'b001,
    SRC_B     = 3'b010,
    SRC_U     = 3'b011,
    SRC_J     = 3'b100,
    SRC_SHAMT = 3'b101
  } imm_src_e;

  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0] entry_q [2];
  logic [XLEN-1:0] entry_d [2];
  logic            err_q, err_d;
  logic [63:0]     imm_wide;
  logic [XLEN-1:0] imm_new;
  logic            push;
  logic            pop;

  // Decode at full 64-bit width so both legal XLEN values are a plain truncation.
  always_comb begin
    imm_wide = {{52{Instr[31]}}, Instr[31:20]};
    case (imm_src_e'(ImmSrc))
      SRC_S:     imm_wide = {{52{Instr[31]}}, Instr[31:25], Instr[11:7]};
      SRC_B:     imm_wide = {{52{Instr[31]}}, Instr[7], Instr[30:25], Instr[11:8], 1'b0};
      SRC_U:     imm_wide = {{32{Instr[31]}}, Instr[31:12], 12'b0};
      SRC_J:     imm_wide = {{44{Instr[31]}}, Instr[19:12], Instr[20], Instr[30:21], 1'b0};
      SRC_SHAMT: imm_wide = (XLEN == 64) ? {58'b0, Instr[25:20]} : {59'b0, Instr[24:20]};
      default:   imm_wide = {{52{Instr[31]}}, Instr[31:20]};
    endcase
    imm_new = imm_wide[XLEN-1:0];
  end

  assign in_ready  = (count_q != 2'd2) & ~reset;
  assign out_valid = (count_q != 2'd0);
  assign ImmExt    = out_valid ? entry_q[rd_ptr_q] : '0;
  assign ImmSrcErr = err_q;

  // A flush wins over any handshake in the same cycle.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    entry_d  = entry_q;
    err_d    = err_q | (push & ImmSrc[2] & ImmSrc[1]);
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        entry_d[wr_ptr_q] = imm_new;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      err_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      entry_q[0] <= entry_d[0];
      entry_q[1] <= entry_d[1];
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_imm_ext_stage.sv
// Scoreboard bench for imm_ext_stage: the driver records expected immediates on
// acceptance, a negedge monitor compares handshakes, head data and the error flag.
module tb_imm_ext_stage;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:7]     instr;
  logic [2:0]      imm_src;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm_ext;
  logic            imm_src_err;

  int              n_compared   = 0;
  int              n_mismatched = 0;
  logic [XLEN-1:0] exp_q[$];
  logic            err_model    = 1'b0;
  logic [XLEN-1:0] cur_exp      = '0;
  bit              rand_ready   = 1'b0;

  imm_ext_stage #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Instr     (instr),
    .ImmSrc    (imm_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ImmExt    (imm_ext),
    .ImmSrcErr (imm_src_err)
  );

  always #5 clk = ~clk;

  // Reference immediate built from the instruction fields as signed integers.
  function automatic logic [XLEN-1:0] ref_imm(input logic [31:0] w, input logic [2:0] s);
    longint      v;
    logic [63:0] t;
    case (s)
      3'd1: begin
        v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
        if (v >= 2048) v -= 4096;
      end
      3'd2: begin
        v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
            + longint'(w[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      3'd3: begin
        v = longint'(w[31:12]) * 4096;
        if (w[31]) v -= 64'sh1_0000_0000;
      end
      3'd4: begin
        v = longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
            + longint'(w[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      3'd5: v = (XLEN == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
      default: begin
        v = longint'(w[31:20]);
        if (v >= 2048) v -= 4096;
      end
    endcase
    t = v;
    return t[XLEN-1:0];
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Offer one beat and hold it until the buffer takes it.
  task automatic apply_stimulus(input logic [31:0] w, input logic [2:0] s, input logic [XLEN-1:0] e);
    bit done = 1'b0;
    instr    = w[31:7];
    imm_src  = s;
    cur_exp  = e;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 50 cycles, expected 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic push_random();
    logic [31:0] w;
    logic [2:0]  s;
    w = $urandom;
    s = ($urandom_range(15) == 0) ? 3'(6 + $urandom_range(1)) : 3'($urandom_range(5));
    apply_stimulus(w, s, ref_imm(w, s));
  endtask

  always @(posedge reset) begin
    exp_q.delete();
    err_model = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(1));
  end

  // Monitor: compare against the scoreboard, then advance the model for the coming edge.
  always @(negedge clk) begin
    bit accept;
    if (reset) begin
      exp_q.delete();
      err_model = 1'b0;
    end
    check_output("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check_output("in_ready", 64'(in_ready), 64'(exp_q.size() != 2 && !reset));
    check_output("ImmExt", 64'(imm_ext), (exp_q.size() != 0) ? 64'(exp_q[0]) : 64'd0);
    check_output("ImmSrcErr", 64'(imm_src_err), 64'(err_model));
    if (!reset) begin
      if (flush) begin
        exp_q.delete();
      end else begin
        accept = in_valid && (exp_q.size() != 2);
        if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (accept) begin
          exp_q.push_back(cur_exp);
          if (imm_src >= 3'd6) err_model = 1'b1;
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = '0;
    imm_src   = 3'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;

    $display("[TB] directed decode");
    apply_stimulus(32'hFFF00093, 3'd0, 32'hFFFFFFFF);
    apply_stimulus(32'hFE000EE3, 3'd2, 32'hFFFFFFFC);
    apply_stimulus(32'h123450B7, 3'd3, 32'h12345000);
    apply_stimulus(32'h001000EF, 3'd4, 32'h00000800);
    apply_stimulus(32'h01F0D093, 3'd5, 32'h0000001F);
    apply_stimulus(32'hFE112E23, 3'd1, 32'hFFFFFFFC);
    apply_stimulus(32'h00500093, 3'd7, 32'h00000005);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] backpressure");
    out_ready = 1'b0;
    apply_stimulus(32'h00100093, 3'd0, 32'h00000001);
    apply_stimulus(32'h00200093, 3'd0, 32'h00000002);
    fork
      apply_stimulus(32'h00300093, 3'd0, 32'h00000003);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] sustained push/pop");
    for (int i = 0; i < 10; i++) push_random();
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] flush at count 2 and count 1");
    out_ready = 1'b0;
    apply_stimulus(32'h7FF00093, 3'd0, 32'h000007FF);
    apply_stimulus(32'h80000093, 3'd0, 32'hFFFFF800);
    flush    = 1'b1;
    in_valid = 1'b1;
    instr    = 25'h1ABCDE;
    imm_src  = 3'd3;
    cur_exp  = 32'hDEADBEEF;
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    apply_stimulus(32'h00900093, 3'd0, 32'h00000009);
    flush    = 1'b1;
    in_valid = 1'b1;
    instr    = 25'h0F0F0F;
    cur_exp  = 32'hCAFEF00D;
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] asynchronous reset mid-cycle");
    apply_stimulus(32'h04200093, 3'd0, 32'h00000042);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_in_ready", 64'(in_ready), 64'd0);
    check_output("rst_ImmExt", 64'(imm_ext), 64'd0);
    check_output("rst_ImmSrcErr", 64'(imm_src_err), 64'd0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;

    $display("[TB] randomized traffic");
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        push_random();
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_output("drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/imm_ext_stage.md
# imm_ext_stage

Buffered, parametrised immediate extender for the decode stage of the RISC-V core. It decodes all five RV immediate formats (I, S, B, U, J) plus a shift-amount form, sign- or zero-extends them to XLEN, and holds results in a 2-entry skid buffer with valid/ready handshakes on both sides. The block sits between fetch/decode and the execute-stage register, so a downstream stall never drops an immediate. A pipeline flush empties the buffer.

## Interface
- XLEN, 32, datapath width; legal values are 32 and 64 only.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  Instr/ImmSrc valid.
- in_ready  out  1  buffer can accept a beat.
- Instr  in  25  instruction bits [31:7], declared as [31:7].
- ImmSrc  in  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 SHAMT.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head entry.
- ImmExt  out  XLEN  head entry immediate.
- ImmSrcErr  out  1  sticky flag: an illegal ImmSrc (110/111) was accepted.

## Operation
- Format decode, applied at push; `s` = Instr[31] replicated to fill XLEN:
  - I: {s, Instr[31:20]}
  - S: {s, Instr[31:25], Instr[11:7]}
  - B: {s, Instr[7], Instr[30:25], Instr[11:8], 0}
  - U: {s, Instr[31:12], 12'b0}. For XLEN=32 this is exactly Instr[31:12] followed by 12 zeros.
  - J: {s, Instr[19:12], Instr[20], Instr[30:21], 0}
  - SHAMT: zero-extended Instr[24:20] when XLEN=32; zero-extended Instr[25:20] when XLEN=64.
  - 110/111: decode as I and set ImmSrcErr at the push edge.
- Buffer: a 2-entry FIFO, with count in {0,1,2}.
  - Push = in_valid & in_ready. Pop = out_valid & out_ready.
  - in_ready = (count != 2) & ~reset.
  - out_valid = (count != 0).
  - ImmExt = head entry when out_valid=1, otherwise all zeros.
- Count transitions:
  - push only: +1.
  - pop only: -1.
  - push and pop together (count 1): count stays 1; the new entry becomes head after the pop.
  - At count 2, no push is possible. A pop reduces count to 1 and in_ready rises the next cycle.
  - At count 0, no pop is possible. There is no combinational input-to-output bypass.
- Entries are emitted in FIFO order with no reordering and no duplication.
- Flush: at the next edge count becomes 0. Any push or pop in that same cycle is ignored, and the pushed beat is dropped.
  - ImmSrcErr is not cleared by flush. It is cleared only by reset.

## Timing
- Latency: a beat pushed at edge N is presented with out_valid=1 after edge N, when the buffer was empty or the beat becomes head.
- in_ready and out_valid depend only on registered state and reset, never on in_valid or out_ready. This gives no combinational paths from input to output handshakes.
- Sustained throughput: 1 beat/cycle when out_ready is held high.
- While reset is asserted, and asynchronously on its assertion:
  - count=0, out_valid=0, in_ready=0, ImmExt=0, ImmSrcErr=0.
- in_ready goes to 1 in the first cycle after reset deasserts.
- Reset asserted mid-transfer discards all entries immediately.
- Producer rule: in_valid/Instr/ImmSrc must be held until accepted. The consumer may drop out_ready at any time.

## Test plan
- I decode: Instr from 0xFFF00093 (addi x1,x0,-1), ImmSrc=000, out_ready=1 → one cycle later out_valid=1, ImmExt=0xFFFFFFFF. With XLEN=64, ImmExt=0xFFFFFFFFFFFFFFFF.
- B/U/J decode:
  - 0xFE000EE3, B → 0xFFFFFFFC.
  - 0x123450B7, U → 0x12345000.
  - 0x001000EF, J → 0x00000800.
  - 0x01F0D093 (srli x1,x1,31), SHAMT → 0x0000001F.
- Backpressure: hold out_ready=0 and push three beats A, B, C →
  - count reaches 2 and in_ready=0; C is held by the producer.
  - Raise out_ready → A, B, C emerge in order, each exactly once.
- Simultaneous push/pop at count 1, sustained for 10 cycles → out_valid stays 1, one beat per cycle, count stays 1, all values correct.
- Flush with count=2 and a concurrent push → next cycle out_valid=0 and ImmExt=0; the concurrent beat never appears.
- Illegal ImmSrc=111 with 0x00500093 → ImmExt=0x00000005 and ImmSrcErr=1. The flag survives a flush; it clears only when reset is pulsed mid-cycle, which also clears the buffer asynchronously.
